// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: host command, core observation and run-control status
// signals for cpu_run_ctrl. The breakpoint signals exist only when
// CPU_RUN_CTRL_BKPT_EN is defined.
interface cpu_run_ctrl_if #(
   parameter int CNT_W  = 32,
   parameter int STEP_W = 8
);
   logic              cmd_valid;
   logic [1:0]        cmd_op;
   logic [STEP_W-1:0] cmd_arg;
   logic              cmd_ready;
   logic [31:0]       pc;
   logic [31:0]       instr;
`ifdef CPU_RUN_CTRL_BKPT_EN
   logic              bkpt_en;
   logic [31:0]       bkpt_addr;
`endif
   logic              start;
   logic              halted;
   logic [2:0]        halt_cause;
   logic [CNT_W-1:0]  cycle_cnt;
   logic [CNT_W-1:0]  instret;

`ifdef CPU_RUN_CTRL_BKPT_EN
   modport master (
      output cmd_valid, cmd_op, cmd_arg, pc, instr, bkpt_en, bkpt_addr,
      input  cmd_ready, start, halted, halt_cause, cycle_cnt, instret
   );
   modport slave (
      input  cmd_valid, cmd_op, cmd_arg, pc, instr, bkpt_en, bkpt_addr,
      output cmd_ready, start, halted, halt_cause, cycle_cnt, instret
   );
`else
   modport master (
      output cmd_valid, cmd_op, cmd_arg, pc, instr,
      input  cmd_ready, start, halted, halt_cause, cycle_cnt, instret
   );
   modport slave (
      input  cmd_valid, cmd_op, cmd_arg, pc, instr,
      output cmd_ready, start, halted, halt_cause, cycle_cnt, instret
   );
`endif
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller for the single-cycle RISC-V core. Drives the
// core's start enable from HALT/RUN/STEP state, halts on ecall (and on a PC
// breakpoint when CPU_RUN_CTRL_BKPT_EN is defined), and keeps cycle and
// retired-instruction counters.
module cpu_run_ctrl #(
   parameter int CNT_W  = 32,
   parameter int STEP_W = 8
) (
   input logic          clk,
   input logic          reset,
   cpu_run_ctrl_if.slave bus
);

   typedef enum logic [1:0] {ST_HALT, ST_RUN, ST_STEP} state_t;
   typedef enum logic [1:0] {OP_RUN, OP_STEP, OP_HALT, OP_CLR} op_t;
   typedef enum logic [2:0] {
      CAUSE_RESET     = 3'd0,
      CAUSE_HOST      = 3'd1,
      CAUSE_STEP_DONE = 3'd2,
      CAUSE_ECALL     = 3'd3,
      CAUSE_BKPT      = 3'd4
   } cause_t;

   state_t            r_state;
   cause_t            r_cause;
   logic              r_halted;
   logic              r_resume;
   logic [STEP_W-1:0] r_steps_left;
   logic [CNT_W-1:0]  r_cycle_cnt;
   logic [CNT_W-1:0]  r_instret;

   logic              w_ecall;
   logic              w_bkpt;
   logic              w_stop;
   logic              w_start;
   logic              w_cmd_clr;
   logic              w_cmd_halt;
   logic              w_last_step;

   // Stop detection and core enable; reset drops start without waiting for a clock
   always_comb begin
      w_ecall = (bus.instr == 32'h0000_0073);
`ifdef CPU_RUN_CTRL_BKPT_EN
      w_bkpt  = bus.bkpt_en && (bus.pc == bus.bkpt_addr);
`else
      w_bkpt  = 1'b0;
`endif
      // resume masks the stop for one cycle so a halt at ecall/bkpt can step past it
      w_stop      = (w_ecall || w_bkpt) && !r_resume;
      w_start     = !reset && (r_state != ST_HALT) && !w_stop;
      w_cmd_clr   = bus.cmd_valid && (bus.cmd_op == OP_CLR);
      w_cmd_halt  = bus.cmd_valid && (bus.cmd_op == OP_HALT);
      w_last_step = (r_state == ST_STEP) && w_start && (r_steps_left == STEP_W'(1));
   end

   // Run-control FSM with registered halted/halt_cause
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_HALT;
         r_halted     <= 1'b1;
         r_cause      <= CAUSE_RESET;
         r_steps_left <= '0;
         r_resume     <= 1'b0;
      end else begin
         r_resume <= 1'b0;
         case (r_state)
            ST_HALT: begin
               if (bus.cmd_valid && (bus.cmd_op == OP_RUN)) begin
                  r_state  <= ST_RUN;
                  r_halted <= 1'b0;
                  r_resume <= 1'b1;
               end else if (bus.cmd_valid && (bus.cmd_op == OP_STEP)) begin
                  r_state      <= ST_STEP;
                  r_halted     <= 1'b0;
                  r_resume     <= 1'b1;
                  r_steps_left <= (bus.cmd_arg == '0) ? STEP_W'(1) : bus.cmd_arg;
               end
            end
            default: begin
               if ((r_state == ST_STEP) && w_start)
                  r_steps_left <= r_steps_left - STEP_W'(1);
               // stop forces start low, so it never coincides with a retiring last step
               if (w_stop) begin
                  r_state  <= ST_HALT;
                  r_halted <= 1'b1;
                  r_cause  <= w_ecall ? CAUSE_ECALL : CAUSE_BKPT;
               end else if (w_last_step) begin
                  r_state  <= ST_HALT;
                  r_halted <= 1'b1;
                  r_cause  <= CAUSE_STEP_DONE;
               end else if (w_cmd_halt) begin
                  r_state  <= ST_HALT;
                  r_halted <= 1'b1;
                  r_cause  <= CAUSE_HOST;
               end
            end
         endcase
      end
   end

   // Cycle and retire counters; CLR wins over a same-cycle increment
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cycle_cnt <= '0;
         r_instret   <= '0;
      end else begin
         if (w_cmd_clr)
            r_cycle_cnt <= '0;
         else if (r_state != ST_HALT)
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
         if (w_cmd_clr)
            r_instret <= '0;
         else if (w_start)
            r_instret <= r_instret + CNT_W'(1);
      end
   end

   assign bus.cmd_ready  = 1'b1;
   assign bus.start      = w_start;
   assign bus.halted     = r_halted;
   assign bus.halt_cause = r_cause;
   assign bus.cycle_cnt  = r_cycle_cnt;
   assign bus.instret    = r_instret;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed test of cpu_run_ctrl against a trivial core model
// (PC advances by 4 on each start cycle, ecall placed at a chosen address).
// Expected halt snapshots go into a queue; a monitor pops one per halt.
// Breakpoint cases are built only with CPU_RUN_CTRL_BKPT_EN.
module tb_cpu_run_ctrl;

   localparam logic [1:0] OP_RUN  = 2'd0;
   localparam logic [1:0] OP_STEP = 2'd1;
   localparam logic [1:0] OP_HALT = 2'd2;
   localparam logic [1:0] OP_CLR  = 2'd3;

   typedef struct {
      string       tag;
      logic [2:0]  cause;
      logic [31:0] instret;
      logic [31:0] cycles;
      logic [31:0] pc;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [31:0] core_pc;
   logic [31:0] ecall_addr;
   logic        prev_halted;
   int          n_checks;
   int          n_fail;
   exp_t        exp_q[$];

   cpu_run_ctrl_if #(.CNT_W(32), .STEP_W(8)) u_if ();

   cpu_run_ctrl #(.CNT_W(32), .STEP_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core model: PC advances when start is high
   always @(posedge clk or posedge reset) begin
      if (reset) core_pc <= 32'h0;
      else if (u_if.start) core_pc <= core_pc + 32'd4;
   end
   assign u_if.pc    = core_pc;
   assign u_if.instr = (core_pc == ecall_addr) ? 32'h0000_0073 : 32'h0000_0013;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_halt(input string tag, input logic [2:0] cause,
                              input logic [31:0] ir, input logic [31:0] cy,
                              input logic [31:0] pc);
      exp_t e;
      e.tag = tag; e.cause = cause; e.instret = ir; e.cycles = cy; e.pc = pc;
      exp_q.push_back(e);
   endtask

   // Monitor: one expected snapshot per halted rising edge outside reset
   always @(negedge clk) begin
      if (!reset && u_if.halted && !prev_halted) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_halt: got cause %0d expected no halt", u_if.halt_cause);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, "_cause"},   {29'd0, u_if.halt_cause}, {29'd0, e.cause});
            check({e.tag, "_instret"}, u_if.instret,   e.instret);
            check({e.tag, "_cycles"},  u_if.cycle_cnt, e.cycles);
            check({e.tag, "_pc"},      core_pc,        e.pc);
         end
      end
      prev_halted = u_if.halted;
   end

   // Issue one command for a single cycle; returns at the negedge after sampling
   task automatic cmd(input logic [1:0] op, input logic [7:0] arg);
      u_if.cmd_valid = 1'b1;
      u_if.cmd_op    = op;
      u_if.cmd_arg   = arg;
      @(posedge clk);
      @(negedge clk);
      u_if.cmd_valid = 1'b0;
      u_if.cmd_op    = 2'd0;
      u_if.cmd_arg   = 8'd0;
   endtask

   task automatic wait_halt(input string name, input int max_cycles);
      int n;
      n = 0;
      while (!u_if.halted && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      if (!u_if.halted) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: got halted 0 expected 1 within %0d cycles", name, max_cycles);
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      prev_halted    = 1'b1;
      reset          = 1'b1;
      ecall_addr     = 32'h10;
      u_if.cmd_valid = 1'b0;
      u_if.cmd_op    = 2'd0;
      u_if.cmd_arg   = 8'd0;
`ifdef CPU_RUN_CTRL_BKPT_EN
      u_if.bkpt_en   = 1'b0;
      u_if.bkpt_addr = 32'h0;
`endif
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      check("rst_start",   {31'd0, u_if.start},     32'd0);
      check("rst_halted",  {31'd0, u_if.halted},    32'd1);
      check("rst_cause",   {29'd0, u_if.halt_cause}, 32'd0);
      check("rst_cycles",  u_if.cycle_cnt,          32'd0);
      check("rst_instret", u_if.instret,            32'd0);
      check("cmd_ready",   {31'd0, u_if.cmd_ready}, 32'd1);

      // RUN into ecall at 0x10: retires 0,4,8,C
      expect_halt("run_ecall", 3'd3, 32'd4, 32'd5, 32'h10);
      cmd(OP_RUN, 8'd0);
      check("run_start_n1", {31'd0, u_if.start}, 32'd1);
      wait_halt("run_ecall", 20);
      check("ecall_hold_start", {31'd0, u_if.start}, 32'd0);

      // STEP 1 past the ecall
      expect_halt("step1", 3'd2, 32'd5, 32'd6, 32'h14);
      cmd(OP_STEP, 8'd1);
      wait_halt("step1", 10);

      // STEP 0 behaves as 1
      expect_halt("step0", 3'd2, 32'd6, 32'd7, 32'h18);
      cmd(OP_STEP, 8'd0);
      wait_halt("step0", 10);

      // STEP 3
      expect_halt("step3", 3'd2, 32'd9, 32'd10, 32'h24);
      cmd(OP_STEP, 8'd3);
      wait_halt("step3", 10);

      // CLR while halted
      cmd(OP_CLR, 8'd0);
      check("clr_halt_cycles",  u_if.cycle_cnt, 32'd0);
      check("clr_halt_instret", u_if.instret,   32'd0);
      check("clr_halt_halted",  {31'd0, u_if.halted}, 32'd1);

      // RUN, HALT issued in the 6th run cycle; that instruction retires
      ecall_addr = 32'h1000;
      expect_halt("host_halt", 3'd1, 32'd6, 32'd6, 32'h3C);
      cmd(OP_RUN, 8'd0);
      repeat (5) @(negedge clk);
      cmd(OP_HALT, 8'd0);
      wait_halt("host_halt", 5);

      // CLR in the same cycle as a retire
      expect_halt("clr_run", 3'd1, 32'd1, 32'd1, 32'h44);
      cmd(OP_RUN, 8'd0);
      cmd(OP_CLR, 8'd0);
      check("clr_run_instret", u_if.instret,   32'd0);
      check("clr_run_cycles",  u_if.cycle_cnt, 32'd0);
      check("clr_run_halted",  {31'd0, u_if.halted}, 32'd0);
      cmd(OP_HALT, 8'd0);
      wait_halt("clr_run", 5);

      // Reset mid-RUN
      cmd(OP_RUN, 8'd0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_start",  {31'd0, u_if.start},  32'd0);
      check("rst_mid_halted", {31'd0, u_if.halted}, 32'd1);
      @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      check("post_rst_halted",  {31'd0, u_if.halted},     32'd1);
      check("post_rst_cause",   {29'd0, u_if.halt_cause}, 32'd0);
      check("post_rst_cycles",  u_if.cycle_cnt,           32'd0);
      check("post_rst_instret", u_if.instret,             32'd0);
      check("post_rst_pc",      core_pc,                  32'd0);

`ifdef CPU_RUN_CTRL_BKPT_EN
      // Breakpoint at 0x8
      u_if.bkpt_addr = 32'h8;
      u_if.bkpt_en   = 1'b1;
      expect_halt("bkpt", 3'd4, 32'd2, 32'd3, 32'h8);
      cmd(OP_RUN, 8'd0);
      wait_halt("bkpt", 10);

      // ecall and breakpoint together: ecall wins
      do_reset();
      ecall_addr = 32'h8;
      expect_halt("bkpt_ecall", 3'd3, 32'd2, 32'd3, 32'h8);
      cmd(OP_RUN, 8'd0);
      wait_halt("bkpt_ecall", 10);
      u_if.bkpt_en = 1'b0;
`else
      // ecall at 0x8 from reset
      do_reset();
      ecall_addr = 32'h8;
      expect_halt("ecall8", 3'd3, 32'd2, 32'd3, 32'h8);
      cmd(OP_RUN, 8'd0);
      wait_halt("ecall8", 10);
`endif

      repeat (2) @(negedge clk);
      check("queue_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
